// File: rtl/nebula_dmem_wbuf_if.sv
// Bus bundle between the L1 D-cache, the write buffer and the 512-bit dmem adapter port.
// slave = write-buffer view, master = cache/adapter/testbench view.
interface nebula_dmem_wbuf_if #(
  parameter int PADDR_WIDTH = 56,
  parameter int DEPTH       = 4
);
  localparam int CW = $clog2(DEPTH+1);

  logic                   cpu_req_valid;
  logic                   cpu_req_ready;
  logic                   cpu_req_we;
  logic [PADDR_WIDTH-1:0] cpu_req_addr;
  logic [511:0]           cpu_req_wdata;
  logic                   cpu_rsp_valid;
  logic [511:0]           cpu_rsp_rdata;
  logic                   mem_req;
  logic                   mem_we;
  logic [PADDR_WIDTH-1:0] mem_addr;
  logic [511:0]           mem_wdata;
  logic                   mem_ack;
  logic [511:0]           mem_rdata;
  logic                   flush_req;
  logic                   flush_done;
  logic [CW-1:0]          wb_count;

  modport slave (
    input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
    output cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    input  flush_req,
    output flush_done, wb_count
  );

  modport master (
    output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
    input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    output flush_req,
    input  flush_done, wb_count
  );
endinterface

// File: rtl/nebula_dmem_wbuf.sv
// Posted write buffer + single-transaction request queue in front of the dmem adapter.
// Optional NEBULA_WBUF_FWD_EN: reads hitting a queued line are answered from the buffer.
module nebula_dmem_wbuf #(
  parameter int PADDR_WIDTH = 56,
  parameter int DEPTH       = 4
) (
  input logic               clk,
  input logic               rst,
  nebula_dmem_wbuf_if.slave bus
);
  localparam int LW = PADDR_WIDTH - 6;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, RD, WR} state_e;

  state_e                 state_q, state_d;
  logic [LW-1:0]          ent_line_q [DEPTH];
  logic [511:0]           ent_data_q [DEPTH];
  logic [DEPTH-1:0]       ent_vld_q;
  logic [PW-1:0]          head_q, tail_q;
  logic [CW-1:0]          count_q, count_d;
  logic                   rd_pend_q;
  logic [LW-1:0]          rd_line_q;
  logic                   issue_q, mem_we_q;
  logic [PADDR_WIDTH-1:0] mem_addr_q;
  logic [511:0]           mem_wdata_q;
  logic                   rsp_vld_q, flush_done_q;
  logic [511:0]           rsp_data_q;

  logic [LW-1:0] req_line;
  logic          full, wr_ok, rd_ok, acc_wr, acc_rd;
  logic          issue_rd, issue_wr, head_busy, rd_conf;
  logic          co_hit, push, pop;
  logic [PW-1:0] co_idx;
  logic [5:0]    unused_addr_lo;

  assign req_line       = bus.cpu_req_addr[PADDR_WIDTH-1:6];
  assign unused_addr_lo = bus.cpu_req_addr[5:0];
  assign full   = (count_q == CW'(DEPTH));
  assign wr_ok  = !full && !rd_pend_q && !bus.flush_req;
  assign rd_ok  = !rd_pend_q;
  assign acc_wr = bus.cpu_req_valid &&  bus.cpu_req_we && wr_ok;
  assign acc_rd = bus.cpu_req_valid && !bus.cpu_req_we && rd_ok;

  // Pending read conflicts with any queued copy of its line, in flight or not.
  always_comb begin
    rd_conf = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_vld_q[i] && ent_line_q[i] == rd_line_q) rd_conf = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    issue_rd = 1'b0;
    issue_wr = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_pend_q && !rd_conf) begin
          state_d  = RD;
          issue_rd = 1'b1;
        end else if (count_q != '0) begin
          state_d  = WR;
          issue_wr = 1'b1;
        end
      end
      RD, WR:  if (bus.mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Head being issued this cycle is already frozen: its data was latched into mem_wdata_q.
  assign head_busy = (state_q == WR) || issue_wr;

  always_comb begin
    co_hit = 1'b0;
    co_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_vld_q[i] && ent_line_q[i] == req_line && !(head_busy && PW'(i) == head_q)) begin
        co_hit = 1'b1;
        co_idx = PW'(i);
      end
  end

  assign push    = acc_wr && !co_hit;
  assign pop     = (state_q == WR) && bus.mem_ack;
  assign count_d = count_q + CW'(push) - CW'(pop);

`ifdef NEBULA_WBUF_FWD_EN
  logic          fw_hit;
  logic [PW-1:0] fw_idx;
  always_comb begin
    fw_hit = 1'b0;
    fw_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_vld_q[i] && ent_line_q[i] == req_line) begin
        fw_hit = 1'b1;
        fw_idx = PW'(i);
      end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ent_vld_q    <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      rd_pend_q    <= 1'b0;
      rd_line_q    <= '0;
      issue_q      <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rsp_vld_q    <= 1'b0;
      rsp_data_q   <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rsp_vld_q    <= 1'b0;
      flush_done_q <= bus.flush_req && (count_d == '0) && (state_d == IDLE);

      if (issue_rd) begin
        issue_q    <= 1'b1;
        mem_we_q   <= 1'b0;
        mem_addr_q <= {rd_line_q, 6'b0};
      end else if (issue_wr) begin
        issue_q     <= 1'b1;
        mem_we_q    <= 1'b1;
        mem_addr_q  <= {ent_line_q[head_q], 6'b0};
        mem_wdata_q <= ent_data_q[head_q];
      end else if (bus.mem_ack) begin
        issue_q <= 1'b0;
      end

      if (state_q == RD && bus.mem_ack) begin
        rsp_vld_q  <= 1'b1;
        rsp_data_q <= bus.mem_rdata;
        rd_pend_q  <= 1'b0;
      end

`ifdef NEBULA_WBUF_FWD_EN
      if (acc_rd && fw_hit) begin
        rsp_vld_q  <= 1'b1;
        rsp_data_q <= ent_data_q[fw_idx];
      end else if (acc_rd) begin
        rd_pend_q <= 1'b1;
        rd_line_q <= req_line;
      end
`else
      if (acc_rd) begin
        rd_pend_q <= 1'b1;
        rd_line_q <= req_line;
      end
`endif

      if (pop) begin
        ent_vld_q[head_q] <= 1'b0;
        head_q            <= head_q + 1'b1;
      end
      if (push) begin
        ent_vld_q[tail_q] <= 1'b1;
        tail_q            <= tail_q + 1'b1;
      end
    end
  end

  // Entry payload needs no reset; validity lives in ent_vld_q.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_line_q[tail_q] <= req_line;
      ent_data_q[tail_q] <= bus.cpu_req_wdata;
    end else if (acc_wr && co_hit) begin
      ent_data_q[co_idx] <= bus.cpu_req_wdata;
    end
  end

  assign bus.cpu_req_ready = bus.cpu_req_we ? wr_ok : rd_ok;
  assign bus.cpu_rsp_valid = rsp_vld_q;
  assign bus.cpu_rsp_rdata = rsp_data_q;
  // Drop req combinationally on the ack cycle so the adapter never sees a second request.
  assign bus.mem_req       = issue_q && !bus.mem_ack;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.flush_done    = flush_done_q;
  assign bus.wb_count      = count_q;
endmodule

// File: tb/tb_nebula_dmem_wbuf.sv
// Scoreboard bench for nebula_dmem_wbuf: expected mem transactions and read responses are
// queued by the stimulus and consumed by an independent monitor.
module tb_nebula_dmem_wbuf;
  localparam int AW = 56;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nebula_dmem_wbuf_if #(.PADDR_WIDTH(AW), .DEPTH(DEPTH)) bus();
  nebula_dmem_wbuf #(.PADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic we; logic [AW-1:0] addr; logic [511:0] data; } mem_t;
  typedef struct { logic [511:0] data; bit from_mem; } rsp_t;

  mem_t exp_mem[$];
  rsp_t exp_rsp[$];
  int errors = 0, checks = 0;
  int cyc = 0, ack_cyc = -10, acc_cyc = -10;
  int budget = 0, lat = 2, ad_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [511:0] mk(input logic [31:0] s);
    return {16{s}};
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic exp_w(input logic [AW-1:0] a, input logic [511:0] d);
    mem_t m;
    m.we = 1'b1; m.addr = a; m.data = d;
    exp_mem.push_back(m);
  endtask

  task automatic exp_r(input logic [AW-1:0] a);
    mem_t m;
    m.we = 1'b0; m.addr = a; m.data = '0;
    exp_mem.push_back(m);
  endtask

  task automatic exp_d(input logic [511:0] d, input bit from_mem);
    rsp_t r;
    r.data = d; r.from_mem = from_mem;
    exp_rsp.push_back(r);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [511:0] d);
    int n = 0;
    bus.cpu_req_valid = 1'b1; bus.cpu_req_we = we;
    bus.cpu_req_addr  = a;    bus.cpu_req_wdata = d;
    @(negedge clk);
    while (!bus.cpu_req_ready && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!bus.cpu_req_ready) begin
      errors++;
      $display("FAIL send_timeout: addr %0h never accepted, ready=0 required 1", a);
    end else acc_cyc = cyc;
    step();
    bus.cpu_req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    @(negedge clk);
    while (!(exp_mem.size() == 0 && exp_rsp.size() == 0 && bus.wb_count == 0 && !bus.mem_req)
           && n < 1000) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL %s_drain: pending mem=%0d rsp=%0d count=%0d, required all 0",
               nm, exp_mem.size(), exp_rsp.size(), bus.wb_count);
    end
    step();
  endtask

  // Adapter model: acks after lat cycles while the ack budget allows.
  initial begin
    bus.mem_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      if (rst) ad_cnt = 0;
      else if (bus.mem_req && budget > 0) begin
        if (ad_cnt >= lat) begin
          bus.mem_ack = 1'b1; ad_cnt = 0; budget--;
        end else ad_cnt++;
      end
    end
  end

  // Monitor: compares each new mem issue and each read response against the scoreboard.
  initial begin
    mem_t m;
    rsp_t r;
    bit prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mem_ack) begin
        chk("mem_req_low_on_ack", 512'(bus.mem_req), 512'(0));
        ack_cyc = cyc;
      end
      if (bus.mem_req && !prev) begin
        if (exp_mem.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_mem_req: got addr %0h we %0d, required no request",
                   bus.mem_addr, bus.mem_we);
        end else begin
          m = exp_mem.pop_front();
          chk("mem_we",   512'(bus.mem_we),   512'(m.we));
          chk("mem_addr", 512'(bus.mem_addr), 512'(m.addr));
          if (m.we) chk("mem_wdata", bus.mem_wdata, m.data);
        end
      end
      prev = bus.mem_req;
      if (bus.cpu_rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1, required 0");
        end else begin
          r = exp_rsp.pop_front();
          chk("rsp_rdata", bus.cpu_rsp_rdata, r.data);
          if (r.from_mem) chk("rsp_lat_after_ack", 512'(cyc), 512'(ack_cyc + 1));
          else            chk("rsp_lat_after_accept", 512'(cyc), 512'(acc_cyc + 1));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    bus.cpu_req_valid = 1'b0; bus.cpu_req_we = 1'b0;
    bus.cpu_req_addr  = '0;   bus.cpu_req_wdata = '0;
    bus.mem_rdata     = '0;   bus.flush_req = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_mem_req",    512'(bus.mem_req),       512'(0));
    chk("rst_wb_count",   512'(bus.wb_count),      512'(0));
    chk("rst_rsp_valid",  512'(bus.cpu_rsp_valid), 512'(0));
    chk("rst_flush_done", 512'(bus.flush_done),    512'(0));
    chk("rst_mem_addr",   512'(bus.mem_addr),      512'(0));
    step(); rst = 1'b0; step();

    // 1: single line fill, slow adapter
    lat = 20; budget = 1000;
    bus.mem_rdata = mk(32'hD1D1_0001);
    exp_r(56'h1000);
    exp_d(mk(32'hD1D1_0001), 1'b1);
    send(1'b0, 56'h1000, '0);
    wait_drain("t1");

    // 2: fill the buffer while the adapter is stalled
    lat = 2; budget = 0;
    for (int i = 0; i < 4; i++) begin
      exp_w(AW'(i * 64), mk(32'h2000_0000 + i));
      send(1'b1, AW'(i * 64), mk(32'h2000_0000 + i));
    end
    @(negedge clk);
    chk("t2_count_full", 512'(bus.wb_count), 512'(4));
    bus.cpu_req_valid = 1'b1; bus.cpu_req_we = 1'b1;
    bus.cpu_req_addr = 56'h100; bus.cpu_req_wdata = mk(32'hBAD0_BAD0);
    #1 chk("t2_ready_when_full", 512'(bus.cpu_req_ready), 512'(0));
    bus.cpu_req_valid = 1'b0;
    budget = 1;
    for (int n = 0; n < 50 && bus.wb_count != 3; n++) @(negedge clk);
    chk("t2_count_after_ack", 512'(bus.wb_count), 512'(3));
    #1 chk("t2_ready_after_ack", 512'(bus.cpu_req_ready), 512'(1));
    step(); budget = 1000;
    wait_drain("t2");

    // 3: coalescing behind a stalled blocker write
    budget = 0;
    exp_w(56'h180, mk(32'h3333_0180));
    exp_w(56'h200, mk(32'h3333_000B));
    send(1'b1, 56'h180, mk(32'h3333_0180));
    send(1'b1, 56'h200, mk(32'h3333_000A));
    send(1'b1, 56'h23F, mk(32'h3333_000B));
    @(negedge clk);
    chk("t3_count_coalesced", 512'(bus.wb_count), 512'(2));
    step(); budget = 1000;
    wait_drain("t3");

    // 4: read of a line sitting in the buffer
    budget = 0;
    exp_w(56'h300, mk(32'h4444_000B));
    send(1'b1, 56'h300, mk(32'h4444_000B));
`ifdef NEBULA_WBUF_FWD_EN
    exp_d(mk(32'h4444_000B), 1'b0);
`else
    bus.mem_rdata = mk(32'hD4D4_0300);
    exp_r(56'h300);
    exp_d(mk(32'hD4D4_0300), 1'b1);
`endif
    send(1'b0, 56'h300, '0);
    repeat (3) step();
    budget = 1000;
    wait_drain("t4");

    // 5: queued read beats a queued write once the bus frees up
    budget = 0;
    bus.mem_rdata = mk(32'hD5D5_0400);
    exp_w(56'h600, mk(32'h5555_0600));
    exp_r(56'h400);
    exp_w(56'h500, mk(32'h5555_0500));
    exp_d(mk(32'hD5D5_0400), 1'b1);
    send(1'b1, 56'h600, mk(32'h5555_0600));
    send(1'b1, 56'h500, mk(32'h5555_0500));
    send(1'b0, 56'h400, '0);
    @(negedge clk);
    chk("t5_count_queued", 512'(bus.wb_count), 512'(2));
    step(); budget = 1000;
    wait_drain("t5");

    // 6: reset in the middle of a write with three more queued
    budget = 0;
    exp_w(56'h700, mk(32'h6666_0700));
    for (int i = 0; i < 4; i++) send(1'b1, AW'(56'h700 + i * 64), mk(32'h6666_0700 + i));
    @(negedge clk);
    chk("t6_count_before_rst", 512'(bus.wb_count), 512'(4));
    chk("t6_req_before_rst",   512'(bus.mem_req),  512'(1));
    step(); rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_mem_req",   512'(bus.mem_req),       512'(0));
    chk("t6_rst_wb_count",  512'(bus.wb_count),      512'(0));
    chk("t6_rst_rsp_valid", 512'(bus.cpu_rsp_valid), 512'(0));
    step(); rst = 1'b0; budget = 1000;
    repeat (30) step();
    chk("t6_no_req_after_rst", 512'(bus.mem_req),  512'(0));
    chk("t6_count_after_rst",  512'(bus.wb_count), 512'(0));
    chk("t6_mem_queue_empty",  512'(exp_mem.size()), 512'(0));

    // 7: flush drains in order and refuses new writes
    budget = 0;
    exp_w(56'h800, mk(32'h7777_0800));
    exp_w(56'h840, mk(32'h7777_0840));
    send(1'b1, 56'h800, mk(32'h7777_0800));
    send(1'b1, 56'h840, mk(32'h7777_0840));
    bus.flush_req = 1'b1;
    bus.cpu_req_we = 1'b1;
    @(negedge clk);
    chk("t7_done_while_queued", 512'(bus.flush_done),    512'(0));
    chk("t7_wr_refused",        512'(bus.cpu_req_ready), 512'(0));
    step(); budget = 1000;
    begin
      int n = 0;
      @(negedge clk);
      while (!(bus.mem_ack && bus.wb_count == 1) && n < 200) begin @(negedge clk); n++; end
      checks++;
      if (n >= 200) begin
        errors++;
        $display("FAIL t7_last_ack_timeout: last ack not seen, count=%0d required 1", bus.wb_count);
      end
    end
    chk("t7_done_on_ack_cycle", 512'(bus.flush_done), 512'(0));
    @(negedge clk);
    chk("t7_done_after_ack",  512'(bus.flush_done), 512'(1));
    chk("t7_count_drained",   512'(bus.wb_count),   512'(0));
    step(); bus.flush_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t7_done_drops", 512'(bus.flush_done), 512'(0));
    chk("t7_mem_queue_empty", 512'(exp_mem.size()), 512'(0));
    chk("t7_rsp_queue_empty", 512'(exp_rsp.size()), 512'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
